// File: rtl/mux_n_1_pipe.sv
// Registered N:1 data selector with valid/ready on both sides and a two-entry
// skid buffer; out-of-range selects deliver zero data flagged with out_err.
module mux_n_1_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] new_data;
  logic             new_err;
  logic             accept;
  logic             main_free;

  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_err;
  logic             skid_valid;

  logic [WIDTH-1:0] out_d;
  logic [SEL_W-1:0] out_sel_d;
  logic             out_err_d;
  logic             out_valid_d;
  logic [WIDTH-1:0] skid_data_d;
  logic [SEL_W-1:0] skid_sel_d;
  logic             skid_err_d;
  logic             skid_valid_d;
  logic             in_ready_d;

  // Channel select; unused select codes fall through to zero data.
  always_comb begin
    new_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (sel == SEL_W'(k)) new_data = in_flat[k*WIDTH +: WIDTH];
    end
    new_err = (32'(sel) >= N);
  end

  // Next-state for the main (output) entry and the skid entry.
  always_comb begin
    out_d        = out;
    out_sel_d    = out_sel;
    out_err_d    = out_err;
    out_valid_d  = out_valid;
    skid_data_d  = skid_data;
    skid_sel_d   = skid_sel;
    skid_err_d   = skid_err;
    skid_valid_d = skid_valid;

    accept    = in_valid && in_ready;
    main_free = !out_valid || out_ready;

    if (main_free) begin
      if (skid_valid) begin
        out_d        = skid_data;
        out_sel_d    = skid_sel;
        out_err_d    = skid_err;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) begin
          skid_data_d = new_data;
          skid_sel_d  = sel;
          skid_err_d  = new_err;
        end
      end else if (accept) begin
        out_d       = new_data;
        out_sel_d   = sel;
        out_err_d   = new_err;
        out_valid_d = 1'b1;
      end else begin
        // Data fields hold the last drained value once empty.
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = new_data;
      skid_sel_d   = sel;
      skid_err_d   = new_err;
      skid_valid_d = 1'b1;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      out_sel    <= '0;
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
      skid_err   <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      out        <= out_d;
      out_sel    <= out_sel_d;
      out_err    <= out_err_d;
      out_valid  <= out_valid_d;
      skid_data  <= skid_data_d;
      skid_sel   <= skid_sel_d;
      skid_err   <= skid_err_d;
      skid_valid <= skid_valid_d;
      in_ready   <= in_ready_d;
    end
  end

endmodule

// File: doc/mux_n_1_pipe.md
Name: mux_n_1_pipe

Overview:
Parametrised, registered N:1 data selector with a valid/ready handshake on both sides. It is the next generation of the 3:1 operand and write-back selectors in the KGP-RISC datapath. Width, channel count and select width are generalised. A two-entry skid buffer gives full throughput under back-pressure, and out-of-range selects are flagged instead of silently aliasing. It sits between a pipeline stage's source registers and the consuming stage (ALU operand or write-back port).

Parameters:
WIDTH, 32, data width of each input channel and of the output
N, 3, number of input channels (legal range 2..16)
SEL_W, 2, width of the select field; must satisfy 2**SEL_W >= N

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_flat  input  N*WIDTH  packed channels; channel k = in_flat[k*WIDTH +: WIDTH] (channel 0 = in00, 1 = in01, 2 = in10 in the 3:1 case)
sel  input  SEL_W  channel select, sampled with in_valid
in_valid  input  1  upstream offers in_flat/sel this cycle
in_ready  output  1  block can accept this cycle
out  output  WIDTH  selected data of head entry
out_sel  output  SEL_W  select value that produced out
out_err  output  1  head entry had sel >= N
out_valid  output  1  head entry valid
out_ready  input  1  downstream consumes head when out_valid

Behaviour:
- Storage: main register (drives out*) and skid register, each holding {data, sel, err, valid}.
- Accept condition: in_valid && in_ready. Drain condition: out_valid && out_ready.
- Select data: in_flat[sel*WIDTH +: WIDTH] when sel < N. When sel >= N, data is 0 and err is 1, and the entry is still accepted and delivered.
- Latency: an entry accepted in cycle t appears on out/out_valid in cycle t+1 when main is empty or draining in cycle t.
- in_ready is a registered output, equal to !skid.valid. It is never combinationally dependent on out_ready.
- Main-register update per cycle:
  - main empty or draining, skid valid: main <= skid; skid cleared; if also accepting, skid <= new entry.
  - main empty or draining, skid empty, accepting: main <= new entry.
  - main valid and stalled (out_valid && !out_ready), accepting: skid <= new entry; in_ready drops next cycle.
  - otherwise main holds. out, out_sel and out_err stay stable while out_valid && !out_ready.
- Ordering is strictly FIFO. An entry is never dropped or duplicated. At most 2 entries are resident.
- Sustained throughput is 1 entry/cycle while out_ready = 1.
- Full (skid valid): in_ready = 0, and in_valid is ignored.
- Empty: out_valid = 0. out holds the last drained value, with no functional meaning.
- Simultaneous accept and drain with skid empty: main reloads with the new entry, out_valid stays 1, no bubble.
- Reset values (applied while rst = 1 at a clock edge):
  - out = 0, out_sel = 0, out_err = 0, out_valid = 0.
  - skid cleared; in_ready = 0 during reset, 1 on the first cycle after rst deasserts.
- Reset mid-operation discards all resident entries. Nothing resident before reset is ever emitted afterwards.
- No combinational path from in_flat, sel or in_valid to any output.

Test Plan:
- Reset, then in_flat = {24,14,3} (N=3, WIDTH=32), out_ready=1, sel=0,1,2 on consecutive cycles with in_valid=1 -> out = 3, 14, 24 on cycles t+1..t+3; out_sel = 0,1,2; out_err = 0; out_valid high for 3 cycles.
- sel=3 (out of range) with in_valid=1 -> next cycle out=0, out_err=1, out_sel=3, out_valid=1; the following entry with sel=1 -> out=14, out_err=0.
- out_ready=0; offer sel=0 then sel=2 -> out=3 held stable; in_ready=0 from the cycle after the second accept; a third offer is not accepted. Raise out_ready -> out=3, then 24, then in_ready=1.
- Continuous in_valid=1 with alternating sel 1/2 and out_ready toggled 1,0,1,0 -> output sequence 14,24,14,24... in order, with no loss or duplication; scoreboard compares the accepted count to the drained count.
- Assert rst for one cycle while both entries are resident -> next cycle out_valid=0, out=0, in_ready=0; one cycle later in_ready=1; no pre-reset value appears on out.
- Re-parametrise WIDTH=16, N=5, SEL_W=3 with channels 10..14 -> sel=4 gives out=14; sel=5,6,7 give out=0 with out_err=1.
